// File: rtl/exec_control_unit_pkg.sv
// exec_control_unit_pkg: widths, opcodes, instruction field positions and FSM states
package exec_control_unit_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int INSTR_W = 24;
  localparam int OPC_LSB = 20;
  localparam int RD_LSB = 16;
  localparam int RS1_LSB = 12;
  localparam int RS2_LSB = 8;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_SLT = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_MUL = 4'hA;
  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MUL_ITER, WB} state_t;
endpackage

// File: rtl/exec_control_unit_if.sv
// exec_control_unit_if: instruction handshake plus register file read/write ports
interface exec_control_unit_if;
  import exec_control_unit_pkg::*;
  logic instr_valid;
  logic instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0] read_reg_addr_1;
  logic [ADDR_W-1:0] read_reg_addr_2;
  logic [DATA_W-1:0] read_data_1;
  logic [DATA_W-1:0] read_data_2;
  logic reg_write;
  logic [ADDR_W-1:0] write_reg_addr;
  logic [DATA_W-1:0] write_data;
  logic done;
  logic illegal;
  modport master (
    output instr_valid, instr, read_data_1, read_data_2,
    input instr_ready, read_reg_addr_1, read_reg_addr_2, reg_write, write_reg_addr, write_data, done, illegal
  );
  modport slave (
    input instr_valid, instr, read_data_1, read_data_2,
    output instr_ready, read_reg_addr_1, read_reg_addr_2, reg_write, write_reg_addr, write_data, done, illegal
  );
endinterface

// File: rtl/exec_control_unit_seq_multiplier.sv
// seq_multiplier: shift-add multiplier, one bit per cycle, low half of the product
module seq_multiplier #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] product
);
  localparam int CW = $clog2(W);
  logic [W-1:0] mcand, mplier, acc;
  logic [CW-1:0] cnt;
  assign done = busy && cnt == CW'(W - 1);
  // value the accumulator takes at the end of the current iteration
  assign product = acc + (mplier[0] ? mcand : '0);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
      busy <= 1'b0;
    end else if (start) begin
      mcand <= a;
      mplier <= b;
      acc <= '0;
      cnt <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      acc <= product;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + 1'b1;
      busy <= !done;
    end
  end
endmodule

// File: rtl/exec_control_unit.sv
// exec_control_unit: multi-cycle execute/write-back sequencer in front of the register file
module exec_control_unit
  import exec_control_unit_pkg::*;
(
  input logic clock,
  input logic reset,
  exec_control_unit_if.slave bus
);
  state_t state, next;
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0] op_a, op_b, alu, result, m_product;
  logic [ADDR_W-1:0] waddr, rd;
  logic [3:0] opc;
  logic bad, writes, m_busy, m_done;
  assign opc = ir[OPC_LSB +: 4];
  assign rd = ir[RD_LSB +: ADDR_W];
  assign bad = opc > OP_MUL;
  assign writes = opc != OP_NOP && !bad;
  seq_multiplier #(.W(DATA_W)) u_mul (
    .clock(clock), .reset(reset), .start(state == EXEC && opc == OP_MUL),
    .a(op_a), .b(op_b), .busy(m_busy), .done(m_done), .product(m_product)
  );
  always_comb begin
    next = state == IDLE     ? (bus.instr_valid ? DECODE : IDLE) :
           state == DECODE   ? EXEC :
           state == EXEC     ? (opc == OP_MUL ? MUL_ITER : WB) :
           state == MUL_ITER ? (m_done ? WB : MUL_ITER) : IDLE;
  end
  always_comb begin
    alu = '0;
    case (opc)
      OP_LOAD: alu = ir[DATA_W-1:0];
      OP_ADD:  alu = op_a + op_b;
      OP_SUB:  alu = op_a - op_b;
      OP_AND:  alu = op_a & op_b;
      OP_OR:   alu = op_a | op_b;
      OP_XOR:  alu = op_a ^ op_b;
      OP_SLT:  alu = {{(DATA_W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SHL:  alu = op_a << op_b[3:0];
      OP_SHR:  alu = op_a >> op_b[3:0];
      default: alu = '0;
    endcase
  end
  // result and destination only change when a write is issued, so they hold otherwise
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ir <= '0;
      op_a <= '0;
      op_b <= '0;
      result <= '0;
      waddr <= '0;
    end else begin
      state <= next;
      if (state == IDLE && bus.instr_valid) ir <= bus.instr;
      if (state == DECODE) begin
        op_a <= bus.read_data_1;
        op_b <= bus.read_data_2;
      end
      if (state == EXEC && writes && opc != OP_MUL) begin
        result <= alu;
        waddr <= rd;
      end
      if (state == MUL_ITER && m_done) begin
        result <= m_product;
        waddr <= rd;
      end
    end
  end
  assign bus.instr_ready = state == IDLE && !m_busy;
  assign bus.read_reg_addr_1 = ir[RS1_LSB +: ADDR_W];
  assign bus.read_reg_addr_2 = ir[RS2_LSB +: ADDR_W];
  assign bus.reg_write = state == WB && writes;
  assign bus.write_reg_addr = waddr;
  assign bus.write_data = result;
  assign bus.done = state == WB;
  assign bus.illegal = state == WB && bad;
endmodule

// File: tb/tb_exec_control_unit.sv
// tb_exec_control_unit: reference-model checking of the execute sequencer with a bench register file
module tb_exec_control_unit;
  logic clock = 1'b0;
  logic reset = 1'b0;
  exec_control_unit_if bus();
  exec_control_unit dut (.clock(clock), .reset(reset), .bus(bus.slave));
  always #5 clock = ~clock;

  logic [15:0] rf [16] = '{default: 16'h0};
  logic [15:0] mreg [16] = '{default: 16'h0};
  assign bus.read_data_1 = rf[bus.read_reg_addr_1];
  assign bus.read_data_2 = rf[bus.read_reg_addr_2];
  always @(posedge clock) if (bus.reg_write) rf[bus.write_reg_addr] <= bus.write_data;

  int n_checks = 0, n_err = 0;
  int cyc = 0, wb_at = 0, acc_cyc = 0, n_acc = 0, nwrites = 0, last_write_cyc = 0;
  logic pending = 1'b0, e_wr = 1'b0, e_ill = 1'b0;
  logic [3:0] e_rd = '0, e_rs1 = '0, e_rs2 = '0;
  logic [15:0] e_data = '0, last_wd = '0;
  logic [3:0] last_wa = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] imm);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      4'h1: return imm;
      4'h2: return 16'((int'(a) + int'(b)) % 65536);
      4'h3: return 16'((int'(a) - int'(b) + 65536) % 65536);
      4'h4: return a & b;
      4'h5: return a | b;
      4'h6: return a ^ b;
      4'h7: return (sa < sb) ? 16'd1 : 16'd0;
      4'h8: return 16'((int'(a) * (1 << b[3:0])) % 65536);
      4'h9: return 16'(int'(a) / (1 << b[3:0]));
      4'hA: return 16'((longint'(a) * longint'(b)) % 65536);
      default: return 16'h0;
    endcase
  endfunction

  // model: acceptance, expected write-back cycle and architectural register state
  always @(posedge clock) begin
    logic old_ready, v, r;
    logic [23:0] iw;
    old_ready = !(pending && cyc <= wb_at);
    v = bus.instr_valid;
    iw = bus.instr;
    r = reset;
    cyc++;
    if (pending && cyc > wb_at) begin
      if (e_wr) mreg[e_rd] = e_data;
      pending = 1'b0;
    end
    if (r && old_ready && v) begin
      e_rd = iw[19:16];
      e_rs1 = iw[15:12];
      e_rs2 = iw[11:8];
      e_ill = iw[23:20] > 4'hA;
      e_wr = !e_ill && iw[23:20] != 4'h0;
      e_data = model(iw[23:20], mreg[e_rs1], mreg[e_rs2], iw[15:0]);
      wb_at = cyc + (iw[23:20] == 4'hA ? 18 : 2);
      acc_cyc = cyc;
      pending = 1'b1;
      n_acc++;
    end
  end

  always @(negedge reset) begin
    pending = 1'b0;
    last_wa = '0;
    last_wd = '0;
  end

  always @(negedge clock) begin
    logic busy, in_wb;
    if (!reset) begin
      chk("rst_ready", 32'(bus.instr_ready), 1);
      chk("rst_reg_write", 32'(bus.reg_write), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_illegal", 32'(bus.illegal), 0);
      chk("rst_waddr", 32'(bus.write_reg_addr), 0);
      chk("rst_wdata", 32'(bus.write_data), 0);
      chk("rst_raddr1", 32'(bus.read_reg_addr_1), 0);
      chk("rst_raddr2", 32'(bus.read_reg_addr_2), 0);
    end else begin
      busy = pending && cyc <= wb_at;
      in_wb = pending && cyc == wb_at;
      if (in_wb && e_wr) begin
        last_wa = e_rd;
        last_wd = e_data;
      end
      chk("ready", 32'(bus.instr_ready), 32'(!busy));
      chk("reg_write", 32'(bus.reg_write), 32'(in_wb && e_wr));
      chk("done", 32'(bus.done), 32'(in_wb));
      chk("illegal", 32'(bus.illegal), 32'(in_wb && e_ill));
      chk("waddr", 32'(bus.write_reg_addr), 32'(last_wa));
      chk("wdata", 32'(bus.write_data), 32'(last_wd));
      if (busy) begin
        chk("raddr1", 32'(bus.read_reg_addr_1), 32'(e_rs1));
        chk("raddr2", 32'(bus.read_reg_addr_2), 32'(e_rs2));
      end
    end
    if (bus.reg_write) begin
      nwrites++;
      last_write_cyc = cyc;
    end
  end

  function automatic logic [23:0] rr(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                                     input logic [3:0] rs2);
    return {op, rd, rs1, rs2, 8'h00};
  endfunction

  function automatic logic [23:0] ld(input logic [3:0] rd, input logic [15:0] imm);
    return {4'h1, rd, imm};
  endfunction

  task automatic issue(input logic [23:0] w);
    int k;
    k = n_acc;
    bus.instr_valid = 1'b1;
    bus.instr = w;
    for (int i = 0; i < 40 && n_acc == k; i++) begin
      @(posedge clock);
      #1;
    end
    if (n_acc == k) chk("issue_timeout", 32'(n_acc), 32'(k + 1));
    #1;
    bus.instr_valid = 1'b0;
    bus.instr = 24'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && pending; i++) begin
      @(posedge clock);
      #1;
    end
    if (pending) chk("drain_timeout", 32'(pending), 0);
    #1;
  endtask

  initial begin
    int w0;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    repeat (2) @(posedge clock);
    #2;
    bus.instr_valid = 1'b1;
    bus.instr = rr(4'h2, 4'hF, 4'h1, 4'h1);
    bus.instr_valid = 1'b0;
    issue(ld(4'h3, 16'h1234));
    drain();
    chk("lat_load", 32'(last_write_cyc - acc_cyc + 1), 3);
    chk("r3_load", 32'(rf[3]), 32'h1234);
    issue(ld(4'h1, 16'hFFFF));
    issue(ld(4'h2, 16'h0001));
    issue(rr(4'h2, 4'h4, 4'h1, 4'h2));
    drain();
    chk("r4_add", 32'(rf[4]), 32'h0000);
    issue(ld(4'h1, 16'h0005));
    issue(ld(4'h2, 16'h0007));
    issue(rr(4'h3, 4'h5, 4'h1, 4'h2));
    drain();
    chk("r5_sub", 32'(rf[5]), 32'hFFFE);
    issue(ld(4'h1, 16'h8000));
    issue(ld(4'h2, 16'h0001));
    issue(rr(4'h7, 4'h8, 4'h1, 4'h2));
    issue(rr(4'h8, 4'h9, 4'h1, 4'h2));
    issue(rr(4'h9, 4'hA, 4'h1, 4'h2));
    issue(rr(4'h5, 4'hB, 4'h1, 4'h2));
    issue(rr(4'h6, 4'hC, 4'h1, 4'h1));
    issue(rr(4'h4, 4'hD, 4'h1, 4'h1));
    drain();
    chk("r8_slt", 32'(rf[8]), 32'h0001);
    chk("r9_shl", 32'(rf[9]), 32'h0000);
    chk("r10_shr", 32'(rf[10]), 32'h4000);
    chk("r11_or", 32'(rf[11]), 32'h8001);
    chk("r12_xor", 32'(rf[12]), 32'h0000);
    chk("r13_and", 32'(rf[13]), 32'h8000);
    issue(ld(4'h1, 16'h0123));
    issue(ld(4'h2, 16'h0010));
    issue(rr(4'hA, 4'h6, 4'h1, 4'h2));
    drain();
    chk("lat_mul", 32'(last_write_cyc - acc_cyc + 1), 19);
    chk("r6_mul", 32'(rf[6]), 32'h1230);
    w0 = nwrites;
    issue(rr(4'hC, 4'hE, 4'h1, 4'h2));
    drain();
    issue(rr(4'h0, 4'hE, 4'h1, 4'h2));
    drain();
    chk("no_write_illegal_nop", 32'(nwrites), 32'(w0));
    chk("r14_untouched", 32'(rf[14]), 32'h0000);
    issue(ld(4'h2, 16'h0007));
    issue(rr(4'h2, 4'h7, 4'h2, 4'h2));
    drain();
    chk("r7_b2b", 32'(rf[7]), 32'h000E);
    issue(ld(4'h1, 16'h0003));
    issue(ld(4'h2, 16'h0005));
    drain();
    w0 = nwrites;
    issue(rr(4'hA, 4'hF, 4'h1, 4'h2));
    repeat (9) @(posedge clock);
    #2 reset = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    repeat (25) @(posedge clock);
    #2;
    chk("no_write_after_reset", 32'(nwrites), 32'(w0));
    chk("r15_dropped", 32'(rf[15]), 32'h0000);
    issue(ld(4'hF, 16'h00AB));
    drain();
    chk("r15_load_after_reset", 32'(rf[15]), 32'h00AB);
    repeat (3) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
